// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and starvation limit.
// Registered one-hot grant, encoded index, valid flag and change pulse.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       gnt_chg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       gnt_q;
    logic [3:0]       gnt_d;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             chg_q;
    logic             chg_d;

    logic [3:0]       cand;
    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       probe;
    logic             owner_req;
    logic             hold_max;
    logic             take;

    // The current owner is never a candidate, so a search always means a new owner.
    assign cand      = req & ~gnt_q;
    assign owner_req = |(req & gnt_q);
    assign hold_max  = (hold_q == HOLD_LAST);

    // Rotating priority search: first candidate at or after ptr, wrapping 3->0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        probe     = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            probe = ptr_q + 2'(k);
            if (cand[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    // State register: all arbiter state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            chg_q   <= chg_d;
        end
    end

    // Next-state logic: release, forced rotation, hold refresh or keep.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        chg_d   = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                take = win_found;
            end
            BUSY: begin
                if (!owner_req) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = '0;
                    end
                end else if (hold_max) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
        if (take) begin
            state_d = BUSY;
            gnt_d   = 4'b0001 << win_idx;
            ptr_d   = win_idx + 2'd1;
            hold_d  = '0;
            chg_d   = 1'b1;
        end
    end

    // Output decode: everything visible is derived from the registered grant.
    always_comb begin
        gnt       = gnt_q;
        gnt_chg   = chg_q;
        gnt_valid = |gnt_q;
        gnt_idx   = 2'd0;
        unique case (1'b1)
            gnt_q[0]: gnt_idx = 2'd0;
            gnt_q[1]: gnt_idx = 2'd1;
            gnt_q[2]: gnt_idx = 2'd2;
            gnt_q[3]: gnt_idx = 2'd3;
            default:  gnt_idx = 2'd0;
        endcase
    end

    a_onehot : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_hold : assert property (
        @(posedge clk) disable iff (!rst_n) hold_q <= HOLD_LAST);
    a_state : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == BUSY) == (gnt_q != 4'b0000));

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios plus randomized traffic
// checked every cycle against a behavioural owner/pointer model.
module tb_rr_arbiter4;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       gnt_chg;

    int errors = 0;
    int checks = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_run   = 0;
    bit m_chg   = 1'b0;

    rr_arbiter4 #(.MAX_HOLD(MH), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt_chg   (gnt_chg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p,
                                input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    // Model: who owns the resource, where the search starts, how long held.
    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_run   = 0;
            m_chg   = 1'b0;
        end else begin
            m_chg = 1'b0;
            w     = -1;
            if (m_owner < 0) begin
                w = pick(req, m_ptr, -1);
            end else if (!req[m_owner]) begin
                w = pick(req, m_ptr, m_owner);
                if (w < 0) m_owner = -1;
            end else if (m_run == MH) begin
                w = pick(req, m_ptr, m_owner);
                if (w < 0) m_run = 1;
            end else begin
                m_run++;
            end
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % 4;
                m_run   = 1;
                m_chg   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("m_gnt", {28'd0, gnt},
              (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("m_idx", {30'd0, gnt_idx},
              (m_owner < 0) ? 32'd0 : m_owner);
        check("m_valid", {31'd0, gnt_valid}, {31'd0, m_owner >= 0});
        check("m_chg", {31'd0, gnt_chg}, {31'd0, m_chg});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_valid", {31'd0, gnt_valid}, 32'd0);
        check("rst_chg", {31'd0, gnt_chg}, 32'd0);
        rst_n = 1'b1;

        // T2: single requester, then release
        req = 4'b0100;
        @(negedge clk);
        check("t2_gnt", {28'd0, gnt}, 32'h4);
        check("t2_idx", {30'd0, gnt_idx}, 32'd2);
        check("t2_chg1", {31'd0, gnt_chg}, 32'd1);
        @(negedge clk);
        check("t2_chg2", {31'd0, gnt_chg}, 32'd0);
        @(negedge clk);
        check("t2_hold", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        @(negedge clk);
        check("t2_rel", {28'd0, gnt}, 32'h0);
        check("t2_valid", {31'd0, gnt_valid}, 32'd0);

        // T4/T6: release hand-off without bubble, then pointer wrap
        req = 4'b0010;
        @(negedge clk);
        check("t4_own1", {28'd0, gnt}, 32'h2);
        req = 4'b1010;
        @(negedge clk);
        check("t4_keep", {28'd0, gnt}, 32'h2);
        req = 4'b1000;
        @(negedge clk);
        check("t4_swap", {28'd0, gnt}, 32'h8);
        check("t4_chg", {31'd0, gnt_chg}, 32'd1);
        req = 4'b0011;
        @(negedge clk);
        check("t6_gnt", {28'd0, gnt}, 32'h1);
        check("t6_idx", {30'd0, gnt_idx}, 32'd0);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // T1: reset mid-grant clears immediately, restart from ptr 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        check("t1_pre", {28'd0, gnt}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("t1_gnt", {28'd0, gnt}, 32'h0);
        check("t1_idx", {30'd0, gnt_idx}, 32'd0);
        check("t1_valid", {31'd0, gnt_valid}, 32'd0);
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_post", {28'd0, gnt}, 32'h8);
        check("t1_chg", {31'd0, gnt_chg}, 32'd1);
        req = 4'b0000;
        @(negedge clk);

        // T3: all requesting, forced rotation every MH cycles
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t3_gnt", {28'd0, gnt}, 32'd1 << ((k / MH) % 4));
            check("t3_chg", {31'd0, gnt_chg}, {31'd0, (k % MH) == 0});
        end
        req = 4'b0000;
        @(negedge clk);

        // T5: sole requester keeps grant past the hold limit
        req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t5_gnt", {28'd0, gnt}, 32'h4);
            check("t5_chg", {31'd0, gnt_chg}, {31'd0, k == 0});
        end
        req = 4'b0000;
        @(negedge clk);

        // Random sticky traffic with occasional async reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
